// File: rtl/dpram_pkg.sv
// dpram_pkg: shared reader state type and default widths for dpram clients.
package dpram_pkg;

  localparam int DPRAM_ADDR_W = 10;
  localparam int DPRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// dpram_stream_reader_if: one dpram read port plus the valid/ready output stream.
// master = the reader (drives address/enable and stream), slave = RAM + consumer side.
interface dpram_stream_reader_if import dpram_pkg::*; #(
  parameter int ADDR_W = DPRAM_ADDR_W,
  parameter int DATA_W = DPRAM_DATA_W
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output ram_addr, ram_rd, out_data, out_valid,
    input  ram_q, out_ready
  );

  modport slave (
    input  ram_addr, ram_rd, out_data, out_valid,
    output ram_q, out_ready
  );

endinterface

// File: rtl/sync_fifo_small.sv
// sync_fifo_small: tiny register-based FIFO; head is read straight from the storage registers.
// flush empties the FIFO and takes priority over a same-cycle push.
module sync_fifo_small #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: fetches LEN words from a dpram read port starting at BASE and streams them
// out on valid/ready. A small prefetch FIFO absorbs the RAM's one-cycle read latency; a read is
// only issued when the FIFO is guaranteed room for it, so returning data is never dropped.
module dpram_stream_reader import dpram_pkg::*; #(
  parameter int ADDR_W     = DPRAM_ADDR_W,
  parameter int DATA_W     = DPRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  dpram_stream_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  rd_state_t         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic              inflight_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_head;
  logic              rd_issue;

  // Reserve a FIFO slot for the read still in flight; no new read in a cycle that aborts.
  assign rd_issue = (state_reg == ST_RUN) && !abort && (remaining_reg != '0) && !fifo_full &&
                    ((int'(fifo_count) + int'(inflight_reg)) < FIFO_DEPTH);

  assign fifo_flush = abort && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
  assign fifo_pop   = !fifo_empty && bus.out_ready;

  sync_fifo_small #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .flush     (fifo_flush),
    .push      (inflight_reg),
    .push_data (bus.ram_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.ram_addr  = addr_reg;
  assign bus.ram_rd    = rd_issue;
  assign bus.out_data  = fifo_head;
  assign bus.out_valid = !fifo_empty;
  assign busy          = busy_reg;
  assign done          = done_reg;

  // Transfer FSM with address/remaining counters, in-flight tracking and registered busy/done.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      inflight_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      inflight_reg <= rd_issue;
      done_reg     <= 1'b0;
      if (rd_issue) begin
        addr_reg      <= addr_reg + 1'b1;
        remaining_reg <= remaining_reg - ONE;
      end
      case (state_reg)
        ST_IDLE: begin
          // abort in the same cycle suppresses the start
          if (start && !abort) begin
            addr_reg      <= base_addr;
            remaining_reg <= length;
            if (length == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (rd_issue && (remaining_reg == ONE)) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort || (fifo_empty && !inflight_reg)) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
